// File: rtl/issue_slot_fsm.sv
// rtl/issue_slot_fsm.sv - one issue slot of a multi-cycle MIPS-style control FSM
// Instruction fields are latched on fetch grant; controls decode from state, gated by stall/flush.
module issue_slot_fsm #(
    parameter int SLOT_ID = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_in,
    input  logic        fetch_ack,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic        flush,
    output logic        fetch_req,
    output logic        next_en,
    output logic        retire,
    output logic [3:0]  state,
    output logic [3:0]  next_state,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    output logic [4:0]  rd_addr,
    output logic [2:0]  slot_id,
    output logic        IR_Write,
    output logic        PCWrite,
    output logic [1:0]  PC_Src,
    output logic        Branch,
    output logic        Branch_ne,
    output logic        Branch_gz,
    output logic        MemtoReg,
    output logic        MemWrite,
    output logic        IorD,
    output logic        RegDst,
    output logic        RegWrite,
    output logic [1:0]  ALUOp,
    output logic        ALU_SrcA,
    output logic [1:0]  ALU_SrcB
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB   = 4'd4,  S_MEMWR   = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_BRANCH  = 4'd8,  S_ADDI_EX = 4'd9,  S_ADDI_WB = 4'd10, S_JUMP  = 4'd11,
        S_JR      = 4'd12, S_IDLE    = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW  = 6'b100011, OP_SW   = 6'b101011,
                           OP_BEQ   = 6'b000100, OP_BNE = 6'b000101, OP_BGTZ = 6'b000111,
                           OP_ADDI  = 6'b001000, OP_J   = 6'b000010, FN_JR   = 6'b001000;

    state_t     cur, nxt;
    logic       pending;
    logic [5:0] opcode, funct;
    logic       active;

    assign active     = !stall && !flush;
    assign state      = cur;
    assign next_state = nxt;
    assign slot_id    = 3'(SLOT_ID);

    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE:  if (en_in || pending) nxt = S_FETCH;
            S_FETCH: if (fetch_ack) nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:             nxt = S_MEMADR;
                    OP_RTYPE:                 nxt = (funct == FN_JR) ? S_JR : S_EXEC;
                    OP_BEQ, OP_BNE, OP_BGTZ:  nxt = S_BRANCH;
                    OP_ADDI:                  nxt = S_ADDI_EX;
                    OP_J:                     nxt = S_JUMP;
                    default:                  nxt = S_IDLE;
                endcase
            end
            S_MEMADR:  nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   nxt = S_MEMWB;
            S_EXEC:    nxt = S_ALUWB;
            S_ADDI_EX: nxt = S_ADDI_WB;
            default:   nxt = S_IDLE;
        endcase
        if (flush)      nxt = S_IDLE;
        else if (stall) nxt = cur;
    end

    always_comb begin
        fetch_req = 1'b0; next_en = 1'b0; retire = 1'b0;
        IR_Write = 1'b0; PCWrite = 1'b0; PC_Src = 2'b00;
        Branch = 1'b0; Branch_ne = 1'b0; Branch_gz = 1'b0;
        MemtoReg = 1'b0; MemWrite = 1'b0; IorD = 1'b0;
        RegDst = 1'b0; RegWrite = 1'b0; ALUOp = 2'b00;
        ALU_SrcA = 1'b0; ALU_SrcB = 2'b00;
        if (active) begin
            case (cur)
                S_FETCH: begin
                    fetch_req = 1'b1;
                    IR_Write  = fetch_ack;
                end
                // S1 always leaves when not stalled, so this is a single pulse.
                S_DECODE: begin
                    next_en = 1'b1;
                    retire  = (nxt == S_IDLE);
                end
                S_MEMADR, S_ADDI_EX: begin
                    ALU_SrcA = 1'b1; ALU_SrcB = 2'b10;
                end
                S_MEMRD: IorD = 1'b1;
                S_MEMWB: begin
                    RegWrite = 1'b1; MemtoReg = 1'b1; retire = 1'b1;
                end
                S_MEMWR: begin
                    IorD = 1'b1; MemWrite = 1'b1; retire = 1'b1;
                end
                S_EXEC: begin
                    ALU_SrcA = 1'b1; ALUOp = 2'b10;
                end
                S_ALUWB: begin
                    RegWrite = 1'b1; RegDst = 1'b1; retire = 1'b1;
                end
                S_BRANCH: begin
                    ALU_SrcA  = 1'b1; ALUOp = 2'b01; PC_Src = 2'b01; retire = 1'b1;
                    Branch    = (opcode == OP_BEQ);
                    Branch_ne = (opcode == OP_BNE);
                    Branch_gz = (opcode == OP_BGTZ);
                end
                S_ADDI_WB: begin
                    RegWrite = 1'b1; retire = 1'b1;
                end
                S_JUMP: begin
                    PCWrite = 1'b1; PC_Src = 2'b10; retire = 1'b1;
                end
                S_JR: begin
                    PCWrite = 1'b1; PC_Src = 2'b11; retire = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur     <= S_IDLE;
            pending <= 1'b0;
            opcode  <= '0;
            funct   <= '0;
            rs_addr <= '0;
            rt_addr <= '0;
            rd_addr <= '0;
        end else begin
            cur <= nxt;
            // A token arriving on the IDLE->S0 edge is absorbed by that fetch.
            if (flush)
                pending <= 1'b0;
            else if (cur == S_IDLE && nxt == S_FETCH)
                pending <= 1'b0;
            else if (en_in)
                pending <= 1'b1;
            if (cur == S_FETCH && fetch_ack && active) begin
                opcode  <= instruction[31:26];
                rs_addr <= instruction[25:21];
                rt_addr <= instruction[20:16];
                rd_addr <= instruction[15:11];
                funct   <= instruction[5:0];
            end
        end
    end

endmodule

// File: tb/tb_issue_slot_fsm.sv
// tb/tb_issue_slot_fsm.sv - directed self-checking bench for issue_slot_fsm
module tb_issue_slot_fsm;

    logic        clk = 1'b0;
    logic        rst_n, en_in, fetch_ack, stall, flush;
    logic [31:0] instruction;
    logic        fetch_req, next_en, retire;
    logic [3:0]  state, next_state;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [2:0]  slot_id;
    logic        IR_Write, PCWrite, Branch, Branch_ne, Branch_gz;
    logic        MemtoReg, MemWrite, IorD, RegDst, RegWrite, ALU_SrcA;
    logic [1:0]  PC_Src, ALUOp, ALU_SrcB;
    int          checks = 0;
    int          failures = 0;

    issue_slot_fsm #(.SLOT_ID(3)) dut (
        .clk(clk), .rst_n(rst_n), .en_in(en_in), .fetch_ack(fetch_ack),
        .instruction(instruction), .stall(stall), .flush(flush),
        .fetch_req(fetch_req), .next_en(next_en), .retire(retire),
        .state(state), .next_state(next_state),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .slot_id(slot_id),
        .IR_Write(IR_Write), .PCWrite(PCWrite), .PC_Src(PC_Src),
        .Branch(Branch), .Branch_ne(Branch_ne), .Branch_gz(Branch_gz),
        .MemtoReg(MemtoReg), .MemWrite(MemWrite), .IorD(IorD),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUOp(ALUOp),
        .ALU_SrcA(ALU_SrcA), .ALU_SrcB(ALU_SrcB)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issues a token, grants the fetch next cycle; returns 1 ns after entering S1.
    task automatic go(input logic [31:0] ins);
        en_in = 1'b1;
        cyc();
        en_in = 1'b0;
        fetch_ack = 1'b1;
        instruction = ins;
        cyc();
        fetch_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en_in = 1'b0; fetch_ack = 1'b0; stall = 1'b0; flush = 1'b0;
        instruction = 32'h0;
        #12;
        checks++; if (state !== 4'd15) begin failures++; $display("FAIL reset_state got=%0d exp=15", state); end
        checks++; if ({fetch_req, next_en, retire, RegWrite, PCWrite} !== 5'b0) begin failures++; $display("FAIL reset_outputs got=%b exp=00000", {fetch_req, next_en, retire, RegWrite, PCWrite}); end
        checks++; if (slot_id !== 3'd3) begin failures++; $display("FAIL reset_slot_id got=%0d exp=3", slot_id); end
        checks++; if ({rs_addr, rt_addr, rd_addr} !== 15'd0) begin failures++; $display("FAIL reset_fields got=%h exp=0", {rs_addr, rt_addr, rd_addr}); end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        checks++; if (state !== 4'd15) begin failures++; $display("FAIL idle_after_reset got=%0d exp=15", state); end
    endtask

    task automatic test_add();
        en_in = 1'b1;
        #1;
        checks++; if (next_state !== 4'd0) begin failures++; $display("FAIL add_ns_idle got=%0d exp=0", next_state); end
        cyc();
        en_in = 1'b0;
        checks++; if (state !== 4'd0 || fetch_req !== 1'b1) begin failures++; $display("FAIL add_s0 got=%0d/%b exp=0/1", state, fetch_req); end
        fetch_ack = 1'b1; instruction = 32'h00221820;
        #1;
        checks++; if (IR_Write !== 1'b1 || next_state !== 4'd1) begin failures++; $display("FAIL add_irwrite got=%b/%0d exp=1/1", IR_Write, next_state); end
        cyc();
        fetch_ack = 1'b0;
        checks++; if (state !== 4'd1 || next_en !== 1'b1 || next_state !== 4'd6) begin failures++; $display("FAIL add_s1 got=%0d/%b/%0d exp=1/1/6", state, next_en, next_state); end
        cyc();
        checks++; if (state !== 4'd6 || ALUOp !== 2'b10 || ALU_SrcA !== 1'b1 || next_en !== 1'b0) begin failures++; $display("FAIL add_s6 got=%0d/%b/%b/%b exp=6/10/1/0", state, ALUOp, ALU_SrcA, next_en); end
        cyc();
        checks++; if (state !== 4'd7 || RegWrite !== 1'b1 || RegDst !== 1'b1 || rd_addr !== 5'd3 || retire !== 1'b1) begin failures++; $display("FAIL add_s7 got=%0d/%b/%b/%0d/%b exp=7/1/1/3/1", state, RegWrite, RegDst, rd_addr, retire); end
        cyc();
        checks++; if (state !== 4'd15 || retire !== 1'b0) begin failures++; $display("FAIL add_end got=%0d/%b exp=15/0", state, retire); end
    endtask

    task automatic test_mem();
        go(32'h8C220004);
        cyc();
        checks++; if (state !== 4'd2 || ALU_SrcB !== 2'b10 || ALU_SrcA !== 1'b1) begin failures++; $display("FAIL lw_s2 got=%0d/%b/%b exp=2/10/1", state, ALU_SrcB, ALU_SrcA); end
        cyc();
        checks++; if (state !== 4'd3 || IorD !== 1'b1) begin failures++; $display("FAIL lw_s3 got=%0d/%b exp=3/1", state, IorD); end
        cyc();
        checks++; if (state !== 4'd4 || RegWrite !== 1'b1 || MemtoReg !== 1'b1 || RegDst !== 1'b0 || rt_addr !== 5'd2 || retire !== 1'b1) begin failures++; $display("FAIL lw_s4 got=%0d/%b/%b/%b/%0d/%b exp=4/1/1/0/2/1", state, RegWrite, MemtoReg, RegDst, rt_addr, retire); end
        cyc();
        go(32'hAC220004);
        cyc(); cyc();
        checks++; if (state !== 4'd5 || MemWrite !== 1'b1 || IorD !== 1'b1 || retire !== 1'b1) begin failures++; $display("FAIL sw_s5 got=%0d/%b/%b/%b exp=5/1/1/1", state, MemWrite, IorD, retire); end
        cyc();
    endtask

    task automatic test_branch_jump();
        go(32'h14220003);
        cyc();
        checks++; if (state !== 4'd8 || {Branch, Branch_ne, Branch_gz} !== 3'b010 || PC_Src !== 2'b01 || ALUOp !== 2'b01) begin failures++; $display("FAIL bne_s8 got=%0d/%b/%b/%b exp=8/010/01/01", state, {Branch, Branch_ne, Branch_gz}, PC_Src, ALUOp); end
        cyc();
        go(32'h08000010);
        cyc();
        checks++; if (state !== 4'd11 || PCWrite !== 1'b1 || PC_Src !== 2'b10) begin failures++; $display("FAIL j_s11 got=%0d/%b/%b exp=11/1/10", state, PCWrite, PC_Src); end
        cyc();
        go(32'h03E00008);
        cyc();
        checks++; if (state !== 4'd12 || PCWrite !== 1'b1 || PC_Src !== 2'b11) begin failures++; $display("FAIL jr_s12 got=%0d/%b/%b exp=12/1/11", state, PCWrite, PC_Src); end
        cyc();
        go(32'hFC000000);
        checks++; if (retire !== 1'b1 || next_state !== 4'd15) begin failures++; $display("FAIL illegal_s1 got=%b/%0d exp=1/15", retire, next_state); end
        cyc();
    endtask

    task automatic test_fetch_wait_stall();
        en_in = 1'b1;
        cyc();
        en_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (state !== 4'd0 || fetch_req !== 1'b1) begin failures++; $display("FAIL fetch_wait%0d got=%0d/%b exp=0/1", i, state, fetch_req); end
            cyc();
        end
        fetch_ack = 1'b1; instruction = 32'h00221820;
        cyc();
        fetch_ack = 1'b0;
        cyc();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (state !== 4'd6 || ALUOp !== 2'b00 || next_state !== 4'd6) begin failures++; $display("FAIL stall%0d got=%0d/%b/%0d exp=6/00/6", i, state, ALUOp, next_state); end
            cyc();
        end
        stall = 1'b0;
        #1;
        checks++; if (state !== 4'd6 || ALUOp !== 2'b10) begin failures++; $display("FAIL stall_release got=%0d/%b exp=6/10", state, ALUOp); end
        cyc(); cyc();
    endtask

    task automatic test_flush();
        go(32'h8C220004);
        cyc(); cyc();
        flush = 1'b1;
        #1;
        checks++; if (retire !== 1'b0 || IorD !== 1'b0 || next_state !== 4'd15) begin failures++; $display("FAIL flush_s3 got=%b/%b/%0d exp=0/0/15", retire, IorD, next_state); end
        cyc();
        flush = 1'b0;
        checks++; if (state !== 4'd15 || RegWrite !== 1'b0 || retire !== 1'b0) begin failures++; $display("FAIL flush_after got=%0d/%b/%b exp=15/0/0", state, RegWrite, retire); end
        go(32'h00221820);
        cyc();
        flush = 1'b1; stall = 1'b1;
        cyc();
        flush = 1'b0; stall = 1'b0;
        checks++; if (state !== 4'd15) begin failures++; $display("FAIL flush_stall got=%0d exp=15", state); end
        cyc();
    endtask

    task automatic test_pending();
        go(32'h00221820);
        cyc();
        en_in = 1'b1;
        cyc();
        en_in = 1'b0;
        checks++; if (state !== 4'd7 || retire !== 1'b1) begin failures++; $display("FAIL pend_s7 got=%0d/%b exp=7/1", state, retire); end
        cyc();
        checks++; if (state !== 4'd15 || next_state !== 4'd0) begin failures++; $display("FAIL pend_idle got=%0d/%0d exp=15/0", state, next_state); end
        cyc();
        checks++; if (state !== 4'd0 || fetch_req !== 1'b1) begin failures++; $display("FAIL pend_s0 got=%0d/%b exp=0/1", state, fetch_req); end
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        cyc();
        checks++; if (state !== 4'd15) begin failures++; $display("FAIL pend_consumed got=%0d exp=15", state); end
    endtask

    task automatic test_reset_mid();
        go(32'h8C220004);
        cyc(); cyc(); cyc();
        rst_n = 1'b0;
        #1;
        checks++; if (state !== 4'd15 || RegWrite !== 1'b0 || retire !== 1'b0) begin failures++; $display("FAIL reset_mid got=%0d/%b/%b exp=15/0/0", state, RegWrite, retire); end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        checks++; if (state !== 4'd15 || rt_addr !== 5'd0) begin failures++; $display("FAIL reset_mid_after got=%0d/%0d exp=15/0", state, rt_addr); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mem();
        test_branch_jump();
        test_fetch_wait_stall();
        test_flush();
        test_pending();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/issue_slot_fsm.md
ISSUE_SLOT_FSM -- requirements
Module: issue_slot_fsm

Interface
REQ-001 Parameter SLOT_ID, default 0, static slot index (0..4) reported on slot_id output.
REQ-002 Reset rst_n, asynchronous, active-low; clock clk.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 en_in  input  1  issue token from previous slot, one-cycle pulse.
REQ-006 fetch_ack  input  1  coordinator grant of this slot's fetch request.
REQ-007 instruction  input  32  instruction word, valid in the fetch_ack cycle.
REQ-008 stall  input  1  bubble: hold current state.
REQ-009 flush  input  1  squash the in-flight instruction of this slot.
REQ-010 fetch_req  output  1  fetch request to coordinator.
REQ-011 next_en  output  1  issue token to next slot, one-cycle pulse.
REQ-012 retire  output  1  one-cycle pulse on normal completion.
REQ-013 state  output  4  current state code; next_state  output  4  combinational next state.
REQ-014 rs_addr, rt_addr, rd_addr  output  5 each  fields latched from the fetched instruction.
REQ-015 slot_id  output  3  equals SLOT_ID.
REQ-016 Control outputs: IR_Write 1, PCWrite 1, PC_Src 2, Branch 1, Branch_ne 1, Branch_gz 1, MemtoReg 1, MemWrite 1, IorD 1, RegDst 1, RegWrite 1, ALUOp 2, ALU_SrcA 1, ALU_SrcB 2.

Function
REQ-017 State codes: S0 FETCH=0, S1 DECODE=1, S2 MEMADR=2, S3 MEMRD=3, S4 MEMWB=4, S5 MEMWR=5, S6 EXEC=6, S7 ALUWB=7, S8 BRANCH=8, S9 ADDI_EX=9, S10 ADDI_WB=10, S11 JUMP=11, S12 JR=12, IDLE=15.
REQ-018 IDLE->S0 when en_in=1 or pending token set; else stay IDLE.
REQ-019 S0: fetch_req=1; on fetch_ack=1 latch instruction (opcode, rs, rt, rd, funct), IR_Write=1 same cycle, go S1; else stay S0.
REQ-020 next_en=1 for exactly the single cycle the slot is in S1 (not re-asserted while stalled in S1).
REQ-021 S1 decode: lw 100011 or sw 101011 -> S2; R-type 000000 with funct 001000 -> S12; other R-type -> S6; beq 000100, bne 000101, bgtz 000111 -> S8; addi 001000 -> S9; j 000010 -> S11; any other opcode -> IDLE with retire=1.
REQ-022 S2->S3 for lw, S5 for sw; S3->S4; S6->S7; S9->S10; S4, S5, S7, S8, S10, S11, S12 -> IDLE with retire=1.
REQ-023 Controls (unlisted = 0): S2/S9 ALU_SrcA=1 ALU_SrcB=10 ALUOp=00; S3 IorD=1; S4 RegWrite=1 MemtoReg=1 RegDst=0; S5 IorD=1 MemWrite=1; S6 ALU_SrcA=1 ALU_SrcB=00 ALUOp=10; S7 RegWrite=1 RegDst=1; S10 RegWrite=1 RegDst=0.
REQ-024 S8: ALU_SrcA=1, ALU_SrcB=00, ALUOp=01, PC_Src=01, exactly one of Branch (beq), Branch_ne (bne), Branch_gz (bgtz) =1.
REQ-025 S11: PCWrite=1, PC_Src=10; S12: PCWrite=1, PC_Src=11.
REQ-026 stall=1: state and latched fields held; all control outputs, fetch_req, next_en, retire forced 0.
REQ-027 flush=1: next state IDLE regardless of state; all control outputs, fetch_req, next_en, retire forced 0 that cycle; pending token cleared.
REQ-028 flush has priority over stall; flush in IDLE has no effect except clearing pending token.
REQ-029 en_in=1 while not IDLE sets one-deep pending token; consumed on next IDLE->S0; a second en_in while pending is set is dropped.
REQ-030 next_state output reflects REQ-018..REQ-029 including stall/flush gating.

Reset
REQ-031 rst_n=0: state=IDLE, pending token=0, latched fields=0, all outputs 0 except state=15 and slot_id; release takes effect on first clk edge with rst_n=1; reset mid-instruction aborts without retire.

Verification
REQ-032 add $3,$1,$2 (0x00221820): en_in, fetch_ack next cycle -> states 15,0,1,6,7,15; next_en in S1; S7 RegWrite=1 RegDst=1 rd_addr=3; retire in S7.
REQ-033 lw 0x8C220004: path 0,1,2,3,4; S3 IorD=1; S4 RegWrite=1 MemtoReg=1 rt_addr=2; sw 0xAC220004 ends S5 MemWrite=1.
REQ-034 bne 0x14220003 -> S8 Branch_ne=1 PC_Src=01; j 0x08000010 -> S11 PCWrite=1 PC_Src=10; jr $31 0x03E00008 -> S12 PC_Src=11.
REQ-035 fetch_ack held 0 for 3 cycles -> fetch_req stays 1, state 0; stall 2 cycles in S6 -> state 6 held, ALUOp=00 during stall, then 10.
REQ-036 flush in S3 -> next cycle IDLE, no retire, no RegWrite; flush+stall same cycle -> IDLE.
REQ-037 en_in during S6 -> after retire slot goes IDLE then S0 with fetch_req=1; rst_n pulse low in S4 -> state 15 immediately, RegWrite=0.
